// File: rtl/alu_result_stage.sv
// Execute-to-writeback stage: captures ALU results and flags, holds the architectural
// carry, and buffers results in a small FIFO drained over a valid/ready handshake.
module alu_result_stage #(
  parameter int DW    = 16,
  parameter int RW    = 4,
  parameter int DEPTH = 2,
  parameter int CW    = 16
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [DW-1:0] ALU_OUT,
  input  logic          ALU_ZERO,
  input  logic          ALU_EQUAL,
  input  logic          ALU_CO,
  input  logic [RW-1:0] IN_DEST,
  input  logic          IN_WE,
  input  logic          IN_SETC,
  input  logic          FLUSH,
  output logic          CARRY,
  output logic          FLAG_ZERO,
  output logic          FLAG_EQUAL,
  output logic          WB_VALID,
  input  logic          WB_READY,
  output logic [DW-1:0] WB_DATA,
  output logic [RW-1:0] WB_DEST,
  output logic          WB_WE,
  output logic [CW-1:0] RETIRED
);
  localparam int PW = $clog2(DEPTH);
  localparam int NW = PW + 1;

  logic [DW-1:0] data_mem [DEPTH];
  logic [RW-1:0] dest_mem [DEPTH];
  logic          we_mem   [DEPTH];

  logic [NW-1:0] count, count_nxt, remain;
  logic [PW-1:0] rd_ptr, rd_nxt, wr_ptr, wr_nxt;
  logic          push, pop, load_head;
  logic [DW-1:0] head_data;
  logic [RW-1:0] head_dest;
  logic          head_we;

  assign IN_READY = RST_N & (count < NW'(DEPTH)) & ~FLUSH;
  assign WB_VALID = (count != '0);
  assign push     = IN_VALID & IN_READY;
  assign pop      = WB_VALID & WB_READY;

  always_comb begin
    count_nxt = count;
    rd_nxt    = rd_ptr;
    wr_nxt    = wr_ptr;
    if (FLUSH) begin
      count_nxt = '0;
      rd_nxt    = '0;
      wr_nxt    = '0;
    end else begin
      if (push && !pop) count_nxt = count + NW'(1);
      if (pop && !push) count_nxt = count - NW'(1);
      if (push) wr_nxt = wr_ptr + PW'(1);
      if (pop)  rd_nxt = rd_ptr + PW'(1);
    end
  end

  // Output registers are reloaded with the next head so they hold their last value
  // when the FIFO drains; an entry pushed into an otherwise empty FIFO comes from the inputs.
  always_comb begin
    remain    = count - NW'(pop);
    load_head = !FLUSH && ((remain != '0) || push);
    if (remain == '0) begin
      head_data = ALU_OUT;
      head_dest = IN_DEST;
      head_we   = IN_WE;
    end else begin
      head_data = data_mem[rd_nxt];
      head_dest = dest_mem[rd_nxt];
      head_we   = we_mem[rd_nxt];
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      data_mem[wr_ptr] <= ALU_OUT;
      dest_mem[wr_ptr] <= IN_DEST;
      we_mem[wr_ptr]   <= IN_WE;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      CARRY      <= 1'b0;
      FLAG_ZERO  <= 1'b0;
      FLAG_EQUAL <= 1'b0;
      RETIRED    <= '0;
      WB_DATA    <= '0;
      WB_DEST    <= '0;
      WB_WE      <= 1'b0;
    end else begin
      count  <= count_nxt;
      rd_ptr <= rd_nxt;
      wr_ptr <= wr_nxt;
      if (push) begin
        FLAG_ZERO  <= ALU_ZERO;
        FLAG_EQUAL <= ALU_EQUAL;
        if (IN_SETC) CARRY <= ALU_CO;
      end
      if (pop) RETIRED <= RETIRED + CW'(1);
      if (load_head) begin
        WB_DATA <= head_data;
        WB_DEST <= head_dest;
        WB_WE   <= head_we;
      end
    end
  end
endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: queue-based reference model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_alu_result_stage;
  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [15:0] ALU_OUT = '0;
  logic        ALU_ZERO = 1'b0;
  logic        ALU_EQUAL = 1'b0;
  logic        ALU_CO = 1'b0;
  logic [3:0]  IN_DEST = '0;
  logic        IN_WE = 1'b0;
  logic        IN_SETC = 1'b0;
  logic        FLUSH = 1'b0;
  logic        CARRY, FLAG_ZERO, FLAG_EQUAL, WB_VALID, WB_WE;
  logic        WB_READY = 1'b0;
  logic [15:0] WB_DATA;
  logic [3:0]  WB_DEST;
  logic [15:0] RETIRED;

  int tests = 0;
  int fails = 0;

  alu_result_stage #(.DW(16), .RW(4), .DEPTH(2), .CW(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .ALU_OUT(ALU_OUT), .ALU_ZERO(ALU_ZERO), .ALU_EQUAL(ALU_EQUAL), .ALU_CO(ALU_CO),
    .IN_DEST(IN_DEST), .IN_WE(IN_WE), .IN_SETC(IN_SETC), .FLUSH(FLUSH),
    .CARRY(CARRY), .FLAG_ZERO(FLAG_ZERO), .FLAG_EQUAL(FLAG_EQUAL),
    .WB_VALID(WB_VALID), .WB_READY(WB_READY), .WB_DATA(WB_DATA), .WB_DEST(WB_DEST),
    .WB_WE(WB_WE), .RETIRED(RETIRED)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: entries in a queue, flags and retire count as plain variables.
  typedef struct {
    logic [15:0] d;
    logic [3:0]  r;
    logic        w;
  } ent_t;

  ent_t        q[$];
  ent_t        shown = '{d: 16'h0, r: 4'h0, w: 1'b0};
  ent_t        e;
  logic        m_carry = 1'b0, m_fz = 1'b0, m_fe = 1'b0;
  logic [15:0] m_ret = '0;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q.delete();
      shown   = '{d: 16'h0, r: 4'h0, w: 1'b0};
      m_carry = 1'b0;
      m_fz    = 1'b0;
      m_fe    = 1'b0;
      m_ret   = '0;
    end else begin
      bit do_push, do_pop;
      do_pop  = (q.size() > 0) && WB_READY;
      do_push = IN_VALID && (q.size() < 2) && !FLUSH;
      if (do_pop) begin
        void'(q.pop_front());
        m_ret = m_ret + 16'd1;
      end
      if (FLUSH) q.delete();
      else if (do_push) begin
        e = '{d: ALU_OUT, r: IN_DEST, w: IN_WE};
        q.push_back(e);
        m_fz = ALU_ZERO;
        m_fe = ALU_EQUAL;
        if (IN_SETC) m_carry = ALU_CO;
      end
      if (q.size() > 0) shown = q[0];
    end
  end

  always @(negedge CLK) begin
    chk("in_ready", {31'd0, IN_READY}, {31'd0, RST_N && (q.size() < 2) && !FLUSH});
    chk("wb_valid", {31'd0, WB_VALID}, {31'd0, q.size() > 0});
    chk("carry", {31'd0, CARRY}, {31'd0, m_carry});
    chk("flag_zero", {31'd0, FLAG_ZERO}, {31'd0, m_fz});
    chk("flag_equal", {31'd0, FLAG_EQUAL}, {31'd0, m_fe});
    chk("retired", {16'd0, RETIRED}, {16'd0, m_ret});
    chk("wb_data", {16'd0, WB_DATA}, {16'd0, shown.d});
    chk("wb_dest", {28'd0, WB_DEST}, {28'd0, shown.r});
    chk("wb_we", {31'd0, WB_WE}, {31'd0, shown.w});
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [15:0] d, input logic [3:0] r,
                        input logic w, input logic co, input logic z, input logic eq,
                        input logic sc);
    IN_VALID = v; ALU_OUT = d; IN_DEST = r; IN_WE = w;
    ALU_CO = co; ALU_ZERO = z; ALU_EQUAL = eq; IN_SETC = sc;
  endtask

  initial begin
    // reset held three cycles with IN_VALID high
    set_in(1'b1, 16'h1234, 4'h5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_wb_valid", {31'd0, WB_VALID}, 32'd0);
    chk("rst_carry", {31'd0, CARRY}, 32'd0);
    chk("rst_retired", {16'd0, RETIRED}, 32'd0);
    chk("rst_in_ready", {31'd0, IN_READY}, 32'd0);
    step();
    RST_N = 1'b1;
    set_in(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    chk("post_rst_in_ready", {31'd0, IN_READY}, 32'd1);

    // single pass
    step();
    set_in(1'b1, 16'h0008, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    WB_READY = 1'b1;
    step();
    IN_VALID = 1'b0;
    @(negedge CLK);
    chk("single_valid", {31'd0, WB_VALID}, 32'd1);
    chk("single_data", {16'd0, WB_DATA}, 32'h0008);
    chk("single_dest", {28'd0, WB_DEST}, 32'd3);
    step();
    @(negedge CLK);
    chk("single_drained", {31'd0, WB_VALID}, 32'd0);
    chk("single_retired", {16'd0, RETIRED}, 32'd1);

    // carry chain
    set_in(1'b1, 16'h0000, 4'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    set_in(1'b1, 16'h0011, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    chk("cc_carry_set", {31'd0, CARRY}, 32'd1);
    chk("cc_zero_set", {31'd0, FLAG_ZERO}, 32'd1);
    step();
    set_in(1'b1, 16'h0022, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge CLK);
    chk("cc_carry_hold", {31'd0, CARRY}, 32'd1);
    step();
    IN_VALID = 1'b0;
    @(negedge CLK);
    chk("cc_carry_clr", {31'd0, CARRY}, 32'd0);
    chk("cc_equal", {31'd0, FLAG_EQUAL}, 32'd1);
    step();
    step();
    chk("cc_retired", {16'd0, RETIRED}, 32'd4);

    // backpressure
    WB_READY = 1'b0;
    set_in(1'b1, 16'h0004, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    set_in(1'b1, 16'h0010, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    set_in(1'b1, 16'h0001, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    chk("bp_full", {31'd0, IN_READY}, 32'd0);
    step();
    IN_VALID = 1'b0;
    WB_READY = 1'b1;
    @(negedge CLK);
    chk("bp_head_hold", {16'd0, WB_DATA}, 32'h0004);
    step();
    @(negedge CLK);
    chk("bp_second", {16'd0, WB_DATA}, 32'h0010);
    step();
    @(negedge CLK);
    chk("bp_empty", {31'd0, WB_VALID}, 32'd0);
    chk("bp_retired", {16'd0, RETIRED}, 32'd6);

    // simultaneous push/pop at occupancy one
    for (int i = 1; i <= 6; i++) begin
      set_in(1'b1, 16'(i), 4'(i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      @(negedge CLK);
      chk("pp_data", {16'd0, WB_DATA}, 32'(i));
    end
    IN_VALID = 1'b0;
    step();
    @(negedge CLK);
    chk("pp_retired", {16'd0, RETIRED}, 32'd12);

    // flush with two entries buffered, no pop
    WB_READY = 1'b0;
    set_in(1'b1, 16'h000A, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    set_in(1'b1, 16'h000B, 4'd8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    set_in(1'b1, 16'h000C, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    FLUSH = 1'b1;
    @(negedge CLK);
    chk("fl_in_ready", {31'd0, IN_READY}, 32'd0);
    step();
    FLUSH = 1'b0;
    IN_VALID = 1'b0;
    @(negedge CLK);
    chk("fl_valid", {31'd0, WB_VALID}, 32'd0);
    chk("fl_carry", {31'd0, CARRY}, 32'd1);
    chk("fl_zero", {31'd0, FLAG_ZERO}, 32'd1);
    chk("fl_hold_data", {16'd0, WB_DATA}, 32'h000A);

    // flush coinciding with a pop still retires
    set_in(1'b1, 16'h00D0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    IN_VALID = 1'b0;
    WB_READY = 1'b1;
    FLUSH = 1'b1;
    step();
    FLUSH = 1'b0;
    @(negedge CLK);
    chk("fl_pop_retired", {16'd0, RETIRED}, 32'd13);

    // reset mid-operation
    WB_READY = 1'b0;
    set_in(1'b1, 16'h00E0, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    step();
    IN_VALID = 1'b0;
    RST_N = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, WB_VALID}, 32'd0);
    chk("mid_rst_carry", {31'd0, CARRY}, 32'd0);
    chk("mid_rst_retired", {16'd0, RETIRED}, 32'd0);
    step();
    RST_N = 1'b1;

    // retire counter wrap
    WB_READY = 1'b1;
    IN_VALID = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      ALU_OUT = 16'(i);
      IN_DEST = 4'(i);
      step();
    end
    IN_VALID = 1'b0;
    step();
    @(negedge CLK);
    chk("wrap_preload", {16'd0, RETIRED}, 32'h0000FFFF);
    step();
    IN_VALID = 1'b1;
    step();
    IN_VALID = 1'b0;
    step();
    @(negedge CLK);
    chk("wrap_zero", {16'd0, RETIRED}, 32'h00000000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
